// File: rtl/sdr_reply_pkg.sv
// Shared definitions for the port-1024 reply transmitter: reply codes, FSM states, payload offsets.
package sdr_reply_pkg;

  localparam logic [7:0] REPLY_DISCOVERY  = 8'h02;
  localparam logic [7:0] REPLY_ERASE_DONE = 8'h03;
  localparam logic [7:0] REPLY_SEND_MORE  = 8'h04;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [5:0] OFS_SEQ    = 6'd0;
  localparam logic [5:0] OFS_TYPE   = 6'd4;
  localparam logic [5:0] OFS_MAC    = 6'd5;
  localparam logic [5:0] OFS_BOARD  = 6'd11;
  localparam logic [5:0] OFS_PROTO  = 6'd12;
  localparam logic [5:0] OFS_VER    = 6'd13;
  localparam logic [5:0] OFS_STATUS = 6'd14;

endpackage

// File: rtl/sdr_reply_byte_sel.sv
// Combinational payload byte mux: maps a byte index onto the snapshot fields of the reply.
// Zero latency; the parent registers the result.
module sdr_reply_byte_sel
  import sdr_reply_pkg::*;
#(
  parameter logic [7:0] BOARD_ID     = 8'd6,
  parameter logic [7:0] PROTOCOL_VER = 8'd38
) (
  input  logic [31:0] seq_i,
  input  logic [47:0] mac_i,
  input  logic [7:0]  ver_i,
  input  logic [7:0]  status_i,
  input  logic [7:0]  rtype_i,
  input  logic [5:0]  idx_i,
  output logic [7:0]  byte_o
);

  always_comb begin
    byte_o = 8'h00;
    case (idx_i)
      OFS_SEQ:          byte_o = seq_i[31:24];
      OFS_SEQ + 6'd1:   byte_o = seq_i[23:16];
      OFS_SEQ + 6'd2:   byte_o = seq_i[15:8];
      OFS_SEQ + 6'd3:   byte_o = seq_i[7:0];
      OFS_TYPE:         byte_o = rtype_i;
      OFS_MAC:          byte_o = mac_i[47:40];
      OFS_MAC + 6'd1:   byte_o = mac_i[39:32];
      OFS_MAC + 6'd2:   byte_o = mac_i[31:24];
      OFS_MAC + 6'd3:   byte_o = mac_i[23:16];
      OFS_MAC + 6'd4:   byte_o = mac_i[15:8];
      OFS_MAC + 6'd5:   byte_o = mac_i[7:0];
      OFS_BOARD:        byte_o = BOARD_ID;
      OFS_PROTO:        byte_o = PROTOCOL_VER;
      OFS_VER:          byte_o = ver_i;
      OFS_STATUS:       byte_o = status_i;
      default:          byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/sdr_reply_tx.sv
// Turns parser/EPCS reply requests into fixed-length UDP payloads streamed byte-wise.
// 3 cycles request edge to first byte with immediate grant; data/valid/last hold while ready is low.
module sdr_reply_tx
  import sdr_reply_pkg::*;
#(
  parameter int         PAYLOAD_LEN   = 60,
  parameter logic [7:0] BOARD_ID      = 8'd6,
  parameter logic [7:0] PROTOCOL_VER  = 8'd38,
  parameter int         GRANT_TIMEOUT = 1250000
) (
  input  logic        tx_clock,
  input  logic        reset,
  input  logic        discovery_reply,
  input  logic        erase_done,
  input  logic        send_more,
  input  logic [31:0] sequence_number,
  input  logic [47:0] local_mac,
  input  logic [7:0]  code_version,
  input  logic [7:0]  status,
  output logic        udp_tx_request,
  input  logic        udp_tx_grant,
  output logic [10:0] udp_tx_length,
  output logic [7:0]  udp_tx_data,
  output logic        udp_tx_valid,
  input  logic        udp_tx_ready,
  output logic        udp_tx_last,
  output logic        sending_sync,
  output logic        discovery_ACK,
  output logic        erase_ACK,
  output logic        send_more_ACK,
  output logic        reply_dropped
);

  localparam int         TW       = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [5:0] LAST_IDX = 6'(PAYLOAD_LEN - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(GRANT_TIMEOUT - 1);

  // Request vectors: bit0 discovery, bit1 erase done, bit2 send more.
  logic [2:0]    req_prev_q, pend_q, pend_d, pend_clr, req_edge;
  state_t        state_q, state_d;
  logic [7:0]    type_q, type_d;
  logic [31:0]   seq_q;
  logic [47:0]   mac_q;
  logic [7:0]    ver_q, status_q;
  logic [5:0]    idx_q, idx_d, sel_idx;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d, sel_byte;
  logic          snap;

  assign req_edge = {send_more, erase_done, discovery_reply} & ~req_prev_q;
  assign pend_d   = (pend_q & ~pend_clr) | req_edge;

  sdr_reply_byte_sel #(
    .BOARD_ID     (BOARD_ID),
    .PROTOCOL_VER (PROTOCOL_VER)
  ) u_byte_sel (
    .seq_i    (seq_q),
    .mac_i    (mac_q),
    .ver_i    (ver_q),
    .status_i (status_q),
    .rtype_i  (type_q),
    .idx_i    (sel_idx),
    .byte_o   (sel_byte)
  );

  always_comb begin
    state_d       = state_q;
    pend_clr      = 3'b000;
    type_d        = type_q;
    snap          = 1'b0;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    sel_idx       = idx_q + 6'd1;
    discovery_ACK = 1'b0;
    erase_ACK     = 1'b0;
    send_more_ACK = 1'b0;
    reply_dropped = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pend_q[1]) begin
          pend_clr  = 3'b010;
          type_d    = REPLY_ERASE_DONE;
          erase_ACK = 1'b1;
        end else if (pend_q[2]) begin
          pend_clr      = 3'b100;
          type_d        = REPLY_SEND_MORE;
          send_more_ACK = 1'b1;
        end else if (pend_q[0]) begin
          pend_clr      = 3'b001;
          type_d        = REPLY_DISCOVERY;
          discovery_ACK = 1'b1;
        end
        if (pend_q != 3'b000) begin
          snap    = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        sel_idx = 6'd0;
        if (udp_tx_grant) begin
          state_d = ST_SEND;
          idx_d   = 6'd0;
          data_d  = sel_byte;
        end else if (cnt_q == TO_LAST) begin
          reply_dropped = 1'b1;
          state_d       = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (udp_tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            idx_d   = 6'd0;
            data_d  = 8'h00;
          end else begin
            idx_d  = idx_q + 6'd1;
            data_d = sel_byte;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_clock) begin
    if (reset) begin
      req_prev_q <= 3'b000;
      pend_q     <= 3'b000;
      state_q    <= ST_IDLE;
      type_q     <= 8'h00;
      seq_q      <= 32'h0;
      mac_q      <= 48'h0;
      ver_q      <= 8'h00;
      status_q   <= 8'h00;
      idx_q      <= 6'd0;
      cnt_q      <= '0;
      data_q     <= 8'h00;
    end else begin
      req_prev_q <= {send_more, erase_done, discovery_reply};
      pend_q     <= pend_d;
      state_q    <= state_d;
      type_q     <= type_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      if (snap) begin
        seq_q    <= sequence_number;
        mac_q    <= local_mac;
        ver_q    <= code_version;
        status_q <= status;
      end
    end
  end

  assign udp_tx_length  = 11'(PAYLOAD_LEN);
  assign udp_tx_data    = data_q;
  assign udp_tx_valid   = (state_q == ST_SEND);
  assign udp_tx_last    = (state_q == ST_SEND) && (idx_q == LAST_IDX);
  assign udp_tx_request = (state_q == ST_REQ) || (state_q == ST_SEND);
  assign sending_sync   = (state_q == ST_REQ) || (state_q == ST_SEND);

endmodule

// File: tb/tb_sdr_reply_tx.sv
// Directed bench for sdr_reply_tx: expected payload bytes are queued at stimulus time and
// checked as the DUT streams them out.
module tb_sdr_reply_tx;

  logic        tx_clock = 1'b0;
  logic        reset;
  logic        discovery_reply, erase_done, send_more;
  logic [31:0] sequence_number;
  logic [47:0] local_mac;
  logic [7:0]  code_version, status;
  logic        udp_tx_request, udp_tx_grant, udp_tx_valid, udp_tx_ready, udp_tx_last;
  logic [10:0] udp_tx_length;
  logic [7:0]  udp_tx_data;
  logic        sending_sync, discovery_ACK, erase_ACK, send_more_ACK, reply_dropped;

  logic grant_en = 1'b1;
  logic toggle   = 1'b0;

  always #5 tx_clock = ~tx_clock;
  assign udp_tx_grant = grant_en & udp_tx_request;

  sdr_reply_tx #(
    .PAYLOAD_LEN   (60),
    .BOARD_ID      (8'd6),
    .PROTOCOL_VER  (8'd38),
    .GRANT_TIMEOUT (100)
  ) dut (
    .tx_clock        (tx_clock),
    .reset           (reset),
    .discovery_reply (discovery_reply),
    .erase_done      (erase_done),
    .send_more       (send_more),
    .sequence_number (sequence_number),
    .local_mac       (local_mac),
    .code_version    (code_version),
    .status          (status),
    .udp_tx_request  (udp_tx_request),
    .udp_tx_grant    (udp_tx_grant),
    .udp_tx_length   (udp_tx_length),
    .udp_tx_data     (udp_tx_data),
    .udp_tx_valid    (udp_tx_valid),
    .udp_tx_ready    (udp_tx_ready),
    .udp_tx_last     (udp_tx_last),
    .sending_sync    (sending_sync),
    .discovery_ACK   (discovery_ACK),
    .erase_ACK       (erase_ACK),
    .send_more_ACK   (send_more_ACK),
    .reply_dropped   (reply_dropped)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_disc = 0, n_erase = 0, n_smore = 0, n_drop = 0, n_valid = 0;
  logic [8:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [7:0] t);
    logic [7:0] hdr [0:14];
    hdr = '{sequence_number[31:24], sequence_number[23:16], sequence_number[15:8],
            sequence_number[7:0], t, local_mac[47:40], local_mac[39:32], local_mac[31:24],
            local_mac[23:16], local_mac[15:8], local_mac[7:0], 8'h06, 8'h26,
            code_version, status};
    return (i < 15) ? hdr[i] : 8'h00;
  endfunction

  task automatic push_reply(input logic [7:0] t, input int n);
    for (int i = 0; i < n; i++) sb.push_back({(i == 59), exp_byte(i, t)});
  endtask

  task automatic wait_drain(input string tag);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge tx_clock);
      if (sb.size() == 0 && !sending_sync && !udp_tx_request) break;
    end
    chk(tag, (k < 2000), 1);
  endtask

  initial begin
    udp_tx_ready = 1'b1;
    forever begin
      @(posedge tx_clock);
      #1;
      if (toggle) udp_tx_ready = ~udp_tx_ready;
      else        udp_tx_ready = 1'b1;
    end
  end

  // Output monitor: counts pulses, scores accepted bytes, checks hold under backpressure.
  logic [7:0] prev_dat  = 8'h00;
  logic       prev_stall = 1'b0;
  logic       prev_lacc  = 1'b0;
  always @(negedge tx_clock) begin
    if (discovery_ACK) n_disc++;
    if (erase_ACK)     n_erase++;
    if (send_more_ACK) n_smore++;
    if (reply_dropped) n_drop++;
    if (udp_tx_valid)  n_valid++;
    if (prev_stall) begin
      chk("hold_dat", udp_tx_data, prev_dat);
      chk("hold_vld", udp_tx_valid, 1);
    end
    if (prev_lacc) chk("sync_after_last", sending_sync, 0);
    prev_stall = udp_tx_valid && !udp_tx_ready && !reset;
    prev_lacc  = udp_tx_valid && udp_tx_ready && udp_tx_last && !reset;
    prev_dat   = udp_tx_data;
    if (udp_tx_valid && udp_tx_ready) begin
      chk("byte_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) chk("payload_byte", {udp_tx_last, udp_tx_data}, sb.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, s0, v0, r0, req_cyc, drop_at;
    reset = 1'b1;
    discovery_reply = 1'b0; erase_done = 1'b0; send_more = 1'b0;
    sequence_number = 32'h01020304;
    local_mac       = 48'h001CC0A213DD;
    code_version    = 8'h12;
    status          = 8'h01;
    repeat (3) @(negedge tx_clock);
    chk("rst_handshake", {udp_tx_request, udp_tx_valid, udp_tx_last, sending_sync}, 4'b0);
    chk("rst_pulses", {discovery_ACK, erase_ACK, send_more_ACK, reply_dropped}, 4'b0);
    chk("rst_data", udp_tx_data, 8'h00);
    chk("tx_length", udp_tx_length, 11'd60);
    reset = 1'b0;
    @(negedge tx_clock);

    // Discovery, immediate grant, ready held high; checks 3-cycle latency.
    d0 = n_disc;
    push_reply(8'h02, 60);
    discovery_reply = 1'b1;
    @(negedge tx_clock);
    chk("t1_ack", discovery_ACK, 1);
    discovery_reply = 1'b0;
    @(negedge tx_clock);
    chk("t1_req_phase", {udp_tx_request, udp_tx_valid, sending_sync}, 3'b101);
    @(negedge tx_clock);
    chk("t1_first_valid", udp_tx_valid, 1);
    wait_drain("t1_drain");
    chk("t1_ack_cnt", n_disc - d0, 1);

    // Backpressure: ready toggles every cycle.
    d0 = n_disc;
    sequence_number = 32'hA5A50F0F;
    push_reply(8'h02, 60);
    toggle = 1'b1;
    discovery_reply = 1'b1;
    @(negedge tx_clock);
    discovery_reply = 1'b0;
    wait_drain("t2_drain");
    toggle = 1'b0;
    chk("t2_ack_cnt", n_disc - d0, 1);

    // Simultaneous edges: erase, send-more, discovery served in that order.
    d0 = n_disc; e0 = n_erase; s0 = n_smore;
    push_reply(8'h03, 60);
    push_reply(8'h04, 60);
    push_reply(8'h02, 60);
    discovery_reply = 1'b1; erase_done = 1'b1; send_more = 1'b1;
    wait_drain("t3_drain");
    discovery_reply = 1'b0; erase_done = 1'b0; send_more = 1'b0;
    @(negedge tx_clock);
    chk("t3_disc_cnt", n_disc - d0, 1);
    chk("t3_erase_cnt", n_erase - e0, 1);
    chk("t3_smore_cnt", n_smore - s0, 1);

    // Grant never given: drop on the 100th REQ cycle, then a normal reply.
    grant_en = 1'b0;
    d0 = n_disc; r0 = n_drop; v0 = n_valid;
    req_cyc = 0; drop_at = -1;
    discovery_reply = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge tx_clock);
      if (discovery_ACK) discovery_reply = 1'b0;
      if (udp_tx_request) req_cyc++;
      if (reply_dropped) begin
        drop_at = req_cyc;
        break;
      end
    end
    chk("t4_drop_cycle", drop_at, 100);
    @(negedge tx_clock);
    chk("t4_after_drop", {udp_tx_request, sending_sync, udp_tx_valid}, 3'b000);
    chk("t4_drop_cnt", n_drop - r0, 1);
    chk("t4_no_valid", n_valid - v0, 0);
    grant_en = 1'b1;
    push_reply(8'h02, 60);
    discovery_reply = 1'b1;
    @(negedge tx_clock);
    discovery_reply = 1'b0;
    wait_drain("t4_drain");
    chk("t4_ack_cnt", n_disc - d0, 2);

    // Reset while byte 20 is on the bus.
    sequence_number = 32'hDEADBEEF;
    push_reply(8'h02, 21);
    discovery_reply = 1'b1;
    @(negedge tx_clock);
    discovery_reply = 1'b0;
    repeat (22) @(negedge tx_clock);
    d0 = n_disc; e0 = n_erase; s0 = n_smore;
    reset = 1'b1;
    @(negedge tx_clock);
    chk("t5_rst_handshake", {udp_tx_request, udp_tx_valid, udp_tx_last, sending_sync}, 4'b0);
    chk("t5_rst_data", udp_tx_data, 8'h00);
    chk("t5_sb_consumed", sb.size(), 0);
    reset = 1'b0;
    repeat (4) @(negedge tx_clock);
    chk("t5_idle_after_rst", {udp_tx_request, udp_tx_valid}, 2'b00);
    chk("t5_no_ack", (n_disc - d0) + (n_erase - e0) + (n_smore - s0), 0);
    push_reply(8'h02, 60);
    discovery_reply = 1'b1;
    @(negedge tx_clock);
    discovery_reply = 1'b0;
    wait_drain("t5_drain");

    // Second send_more edge while the first is still pending merges into one reply.
    s0 = n_smore; v0 = n_valid;
    push_reply(8'h02, 60);
    push_reply(8'h04, 60);
    discovery_reply = 1'b1;
    @(negedge tx_clock);
    discovery_reply = 1'b0;
    repeat (10) @(negedge tx_clock);
    send_more = 1'b1;
    @(negedge tx_clock);
    send_more = 1'b0;
    @(negedge tx_clock);
    send_more = 1'b1;
    wait_drain("t6_drain");
    repeat (10) @(negedge tx_clock);
    send_more = 1'b0;
    chk("t6_smore_cnt", n_smore - s0, 1);
    chk("t6_valid_cnt", n_valid - v0, 120);
    chk("t6_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
